// File: rtl/muldiv_ctrl.sv
// Multi-cycle MIPS multiply/divide sequencer: shift-add multiplier and restoring divider, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle combinational product instead.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 sgn;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_nx;
  logic [2*WIDTH-1:0]   mul_res;
  logic [WIDTH+1:0]     div_shl;
  logic [WIDTH+1:0]     div_diff;
  logic [WIDTH:0]       rem_nx;
  logic [WIDTH-1:0]     quo_nx;

  // Magnitude is formed in WIDTH+1 bits so the most-negative operand maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    logic [WIDTH:0] e;
    e = {s & v[WIDTH-1], v};
    if (e[WIDTH]) e = -e;
    return e[WIDTH-1:0];
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, prod_fast;
  // Sign-extending to 2*WIDTH makes the truncated unsigned product correct for both signednesses.
  always_comb begin
    ext_a     = {{WIDTH{sgn & a_i[WIDTH-1]}}, a_i};
    ext_b     = {{WIDTH{sgn & b_i[WIDTH-1]}}, b_i};
    prod_fast = ext_a * ext_b;
  end
`endif

  assign sgn = ~op_i[0];

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    acc_nx   = {mul_sum, acc_q[WIDTH-1:1]};
    mul_res  = neg_q ? -acc_nx : acc_nx;
    div_shl  = {rem_q, quo_q[WIDTH-1]};
    div_diff = div_shl - {2'b00, opb_q};
    rem_nx   = div_diff[WIDTH+1] ? div_shl[WIDTH:0] : div_diff[WIDTH:0];
    quo_nx   = {quo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !cancel_i) begin
          cnt_d  = '0;
          rem_d  = '0;
          neg_d  = sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d = sgn & a_i[WIDTH-1];
          if (op_i[1]) begin
            quo_d = mag(a_i, sgn);
            opb_d = mag(b_i, sgn);
            if (b_i == '0) begin
              hi_d    = a_i;
              lo_d    = '1;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            {hi_d, lo_d} = prod_fast;
            state_d      = S_DONE;
`else
            acc_d   = {{WIDTH{1'b0}}, mag(b_i, sgn)};
            opb_d   = mag(a_i, sgn);
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          {hi_d, lo_d} = mul_res;
          state_d      = S_DONE;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          hi_d    = rneg_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
          lo_d    = neg_q ? -quo_nx : quo_nx;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush drops the op in flight without touching the visible result.
    if (cancel_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    opb_q  <= opb_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
  end

  assign busy_o  = (state_q == S_MUL) || (state_q == S_DIV);
  assign stall_o = busy_o || (state_q == S_IDLE && start_i && !cancel_i);
  assign valid_o = (state_q == S_DONE) && !cancel_i;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start_i, cancel_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         stall_o, busy_o, valid_o;
  logic [W-1:0] hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .cancel_i(cancel_i), .stall_o(stall_o), .busy_o(busy_o), .valid_o(valid_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1]) return (b == 0) ? 1 : W + 1;
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return W + 1;
`endif
  endfunction

  // Called at #1 after a rising edge; returns at #1 into the IDLE cycle after DONE with start_i low.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int lat, n, stall_bad;
    bit seen;
    e = model(op, a, b);
    lat = exp_lat(op, b);
    n = 0;
    stall_bad = 0;
    seen = 0;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1 chk("stall_accept", 64'(stall_o), 64'd1);
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (valid_o) begin
        seen = 1;
        chk("latency", 64'(n), 64'(lat));
        chk("result", {hi_o, lo_o}, e);
        chk("stall_done", 64'(stall_o), 64'd0);
      end else if (!stall_o || !busy_o) begin
        stall_bad++;
      end
    end
    if (!seen) chk("timeout", 64'(n), 64'(lat));
    chk("stall_run", 64'(stall_bad), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int vcnt;
    logic [31:0] ra, rb;
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = 2'd0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_ctrl", {61'd0, valid_o, busy_o, stall_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd0, 32'hFFFF_FFFF, 32'd2);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2);
    run_op(2'd3, 32'h1234_5678, 32'd0);
    run_op(2'd1, 32'd3, 32'd5);
    run_op(2'd3, 32'd9, 32'd2);
    #1 chk("idle_ctrl", {61'd0, valid_o, busy_o, stall_o}, 64'd0);

    // Flush mid-divide keeps the previous result.
    @(posedge clk); #1;
    run_op(2'd3, 32'd100, 32'd7);
    start_i = 1'b1; op_i = 2'd2; a_i = 32'd50; b_i = 32'd3;
    repeat (10) @(posedge clk);
    #1 cancel_i = 1'b1;
    #1 chk("cancel_valid", 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    cancel_i = 1'b0; start_i = 1'b0;
    #1;
    chk("cancel_ctrl", {61'd0, valid_o, busy_o, stall_o}, 64'd0);
    chk("cancel_keep", {hi_o, lo_o}, {32'd2, 32'd14});
    vcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (valid_o) vcnt++; end
    chk("cancel_novalid", 64'(vcnt), 64'd0);

    // Start together with a flush in IDLE is not accepted.
    start_i = 1'b1; cancel_i = 1'b1; op_i = 2'd1; a_i = 32'd7; b_i = 32'd7;
    #1 chk("idle_cancel_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    #1 chk("idle_cancel_busy", 64'(busy_o), 64'd0);

    // Reset mid-operation.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'd2; a_i = 32'd1000; b_i = 32'd9;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("midrst_ctrl", {61'd0, valid_o, busy_o, stall_o}, 64'd0);
    vcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (valid_o) vcnt++; end
    chk("midrst_novalid", 64'(vcnt), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
      run_op(2'($urandom_range(0, 3)), ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
